wm_insert_pipe: RTL and testbench
=================================

// Module: wm_insert_pipe
// PURPOSE
//  Streaming, pipelined watermark insertion engine; parametrised successor of the combinational insertion datapath.
//  Per pixel, blends the host pixel with a weighted neighbourhood mean, using one of two alpha factors chosen by a 2-bit ternary watermark symbol.
//  Sits between the frame pixel fetcher (4-pixel window) and the output frame writer.
//  Processes one frame of frame_len pixels per start pulse.
// PARAMETERS
//  PIX_W   8   pixel width (bits)
//  FRAC_W  8   alpha fractional bits; alpha is unsigned Q1.FRAC_W, where 1.0 = 2**FRAC_W
//  CNT_W   20  width of frame_len and all pixel counters
// PORTS
//  clk        in   1         clock; all logic on rising edge
//  rst        in   1         asynchronous, active-high reset
//  start      in   1         one-cycle pulse; arms a frame (ignored while busy)
//  frame_len  in   CNT_W     pixels in frame; sampled on accepted start
//  busy       out  1         high from accepted start until done
//  done       out  1         one-cycle pulse when the frame is complete
//  in_valid   in   1         input window valid
//  in_ready   out  1         input accepted when in_valid & in_ready
//  d1         in   PIX_W     host pixel
//  d2,d3,d4   in   PIX_W     neighbour pixels (left, up, right)
//  wm_sym     in   2         00 = none, 01 = embed with a1, 10 = embed with a2, 11 = reserved
//  a1,a2      in   FRAC_W+1  alpha factors; quasi-static, sampled with each pixel
//  out_valid  out  1         output pixel valid
//  out_ready  in   1         downstream ready
//  wm_pix     out  PIX_W     watermarked pixel
//  out_last   out  1         high with the final pixel of the frame
// BEHAVIOUR
//  Reset: busy, done, in_ready, out_valid and out_last are 0; wm_pix is 0; all pipeline valids and counters are 0; FSM is IDLE.
//  FSM states:
//   - IDLE -> RUN on start. If frame_len = 0, IDLE -> DONE instead.
//   - RUN -> DRAIN after frame_len inputs are accepted.
//   - DRAIN -> DONE when the out_last beat handshakes.
//   - DONE -> IDLE after 1 cycle. done = 1 only in DONE.
//  Pipeline: 3 stages, latency 3 cycles from input handshake to out_valid when unstalled.
//  Stall: adv = !s3_valid | out_ready. All stages hold when adv = 0; no data is lost or duplicated.
//  in_ready = (state == RUN) & adv & (in_cnt < frame_len). in_ready is 0 in IDLE, DRAIN and DONE.
//  Stage 1:
//   - M = (d2 + 2*d3 + d4 + 2) >> 2, using PIX_W+2-bit internal width.
//   - Select alpha: 01 -> a1, 10 -> a2. Clamp alpha to 2**FRAC_W if larger.
//  Stage 2: P = d1*alpha + M*(2**FRAC_W - alpha), full-width unsigned.
//  Stage 3: R = (P + 2**(FRAC_W-1)) >> FRAC_W. Saturate R to 2**PIX_W - 1.
//  Symbols 00 and 11 bypass the blend: wm_pix = d1, delayed through the same 3 stages.
//  out_last is asserted on the output beat whose out_cnt equals frame_len-1.
//  A start pulse while busy is ignored, and frame_len is not re-sampled.
//  A pulse on start in the same cycle as done is ignored; start is accepted only in IDLE.
//  Output beat ordering always equals input ordering.
//  rst mid-frame: immediate abort. No done pulse; the pipeline is flushed.
// CONFIGURATION
//  WM_STATS_EN defined:
//   - Adds outputs stat_embed[CNT_W] (count of symbols 01/10) and stat_resv[CNT_W] (count of symbol 11).
//   - Both counters are counted at the output handshake.
//   - Both clear on rst and on accepted start, and hold their values after done.
//  WM_STATS_EN undefined: these ports and counters do not exist; the datapath is identical.
// TESTING
//  1. frame_len=1; d1=200, d2=d3=d4=100, wm_sym=01, a1=64 -> wm_pix=125, out_last=1, done one cycle after the output handshake.
//  2. Same pixel with wm_sym=00, then 11, then 10 with a2=300 (clamped) -> wm_pix=200 each time.
//     With WM_STATS_EN: stat_resv=1, stat_embed=1.
//  3. frame_len=16, out_ready=0 for 5 cycles mid-stream -> in_ready drops once the stages fill.
//     Result: exactly 16 outputs, in order, values matching the reference model.
//  4. frame_len=0 with start -> busy high for 1 cycle, done pulses, no in_ready and no out_valid.
//  5. rst asserted after 4 of 8 pixels -> all outputs 0 next edge, no done.
//     A new start then processes a full 8-pixel frame.
//  6. Random d1..d4, wm_sym and alpha (0..511), with random out_ready, over 1000 pixels.
//     Result: every value matches the model, and wm_pix never exceeds 255.

Source files
------------

// File: rtl/wm_insert_pipe.sv
`default_nettype none
// ============================================================================
// Module      : wm_insert_pipe
// Description : Streaming 3-stage watermark insertion engine. Each pixel is
//               blended with the weighted mean of its left/up/right neighbours.
//               The 2-bit watermark symbol selects the alpha factor (a1 or a2);
//               symbols 00 and 11 pass the host pixel through unchanged.
//               One frame of frame_len pixels is processed per start pulse.
// Ports       : clk, rst (async, active-high)
//               start, frame_len        -> frame control in
//               busy, done              -> frame status out
//               in_valid/in_ready, d1..d4, wm_sym, a1, a2 -> pixel window in
//               out_valid/out_ready, wm_pix, out_last      -> pixel out
//               stat_embed, stat_resv   -> symbol counters (WM_STATS_EN only)
// Options     : WM_STATS_EN - adds the output-side symbol statistics counters
// Revision    : 1.0 - initial release
// ============================================================================
module wm_insert_pipe #(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 8,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  frame_len,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  d1,
    input  logic [PIX_W-1:0]  d2,
    input  logic [PIX_W-1:0]  d3,
    input  logic [PIX_W-1:0]  d4,
    input  logic [1:0]        wm_sym,
    input  logic [FRAC_W:0]   a1,
    input  logic [FRAC_W:0]   a2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  wm_pix,
    output logic              out_last
`ifdef WM_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_embed,
    output logic [CNT_W-1:0]  stat_resv
`endif
);

    localparam int                c_PW       = PIX_W + FRAC_W + 2;
    localparam logic [FRAC_W:0]   c_ONE      = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [c_PW-1:0]   c_HALF     = c_PW'(1) << (FRAC_W - 1);
    localparam logic [PIX_W-1:0]  c_PIX_MAX  = {PIX_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_in_cnt;
    logic [CNT_W-1:0]   r_out_cnt;

    logic               r_s1_valid, r_s2_valid, r_s3_valid;
    logic [PIX_W-1:0]   r_s1_d1, r_s1_m, r_s2_d1, r_s3_pix;
    logic [FRAC_W:0]    r_s1_alpha;
    logic [1:0]         r_s1_sym;
    logic               r_s2_byp;
    logic [c_PW-1:0]    r_s2_p;

    logic               w_adv, w_in_fire, w_out_fire, w_start_ok, w_last_beat;
    logic [PIX_W+1:0]   w_sum;
    logic [PIX_W-1:0]   w_m;
    logic [FRAC_W:0]    w_alpha_sel, w_alpha;
    logic [c_PW-1:0]    w_p, w_rnd, w_q;
    logic [PIX_W-1:0]   w_r;

    // Whole pipe moves together; only a blocked output beat stalls it.
    assign w_adv       = !r_s3_valid || out_ready;
    assign in_ready    = (r_state == S_RUN) && w_adv && (r_in_cnt < r_len);
    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = r_s3_valid && out_ready;
    assign w_start_ok  = start && (r_state == S_IDLE);
    assign w_last_beat = r_s3_valid && (r_out_cnt == r_len - CNT_W'(1));

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_s3_valid;
    assign wm_pix    = r_s3_pix;
    assign out_last  = w_last_beat;

    // Stage 1: rounded neighbourhood mean and clamped alpha.
    assign w_sum       = {2'b00, d2} + {1'b0, d3, 1'b0} + {2'b00, d4} + (PIX_W+2)'(2);
    assign w_m         = PIX_W'(w_sum >> 2);
    assign w_alpha_sel = (wm_sym == 2'b10) ? a2 : a1;
    assign w_alpha     = (w_alpha_sel > c_ONE) ? c_ONE : w_alpha_sel;

    // Stage 2: weighted blend; alpha <= 1.0 keeps (1.0 - alpha) non-negative.
    assign w_p = c_PW'(r_s1_d1) * c_PW'(r_s1_alpha)
               + c_PW'(r_s1_m)  * c_PW'(c_ONE - r_s1_alpha);

    // Stage 3: round to nearest and saturate.
    assign w_rnd = r_s2_p + c_HALF;
    assign w_q   = w_rnd >> FRAC_W;
    assign w_r   = (w_q > c_PW'(c_PIX_MAX)) ? c_PIX_MAX : w_q[PIX_W-1:0];

    // Frame control FSM with registered busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_len     <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_in_fire)  r_in_cnt  <= r_in_cnt + CNT_W'(1);
            if (w_out_fire) r_out_cnt <= r_out_cnt + CNT_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_len     <= frame_len;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_busy    <= 1'b1;
                        if (frame_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_in_fire && (r_in_cnt == r_len - CNT_W'(1)))
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_out_fire && w_last_beat) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath registers; data fields load only with a valid beat so wm_pix
    // keeps its last value between beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s1_d1    <= '0;
            r_s1_m     <= '0;
            r_s1_alpha <= '0;
            r_s1_sym   <= '0;
            r_s2_d1    <= '0;
            r_s2_byp   <= 1'b0;
            r_s2_p     <= '0;
            r_s3_pix   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_in_fire;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            if (w_in_fire) begin
                r_s1_d1    <= d1;
                r_s1_m     <= w_m;
                r_s1_alpha <= w_alpha;
                r_s1_sym   <= wm_sym;
            end
            if (r_s1_valid) begin
                r_s2_d1  <= r_s1_d1;
                r_s2_byp <= (r_s1_sym == 2'b00) || (r_s1_sym == 2'b11);
                r_s2_p   <= w_p;
            end
            if (r_s2_valid)
                r_s3_pix <= r_s2_byp ? r_s2_d1 : w_r;
        end
    end

`ifdef WM_STATS_EN
    logic [1:0] r_s2_sym, r_s3_sym;
    logic [CNT_W-1:0] r_stat_embed, r_stat_resv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_sym <= '0;
            r_s3_sym <= '0;
        end else if (w_adv) begin
            if (r_s1_valid) r_s2_sym <= r_s1_sym;
            if (r_s2_valid) r_s3_sym <= r_s2_sym;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_embed <= '0;
            r_stat_resv  <= '0;
        end else if (w_start_ok) begin
            r_stat_embed <= '0;
            r_stat_resv  <= '0;
        end else if (w_out_fire) begin
            if (r_s3_sym == 2'b01 || r_s3_sym == 2'b10)
                r_stat_embed <= r_stat_embed + CNT_W'(1);
            else if (r_s3_sym == 2'b11)
                r_stat_resv <= r_stat_resv + CNT_W'(1);
        end
    end

    assign stat_embed = r_stat_embed;
    assign stat_resv  = r_stat_resv;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wm_insert_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_wm_insert_pipe
// Description : Self-checking bench for wm_insert_pipe. Expected pixels come
//               from an arithmetic model of the blend rules; the stream is
//               checked beat by beat, plus frame control and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wm_insert_pipe;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [19:0] frame_len;
    logic        busy, done, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0]  d1, d2, d3, d4, wm_pix;
    logic [1:0]  wm_sym;
    logic [8:0]  a1, a2;
`ifdef WM_STATS_EN
    logic [19:0] stat_embed, stat_resv;
`endif

    wm_insert_pipe dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .wm_sym(wm_sym), .a1(a1), .a2(a2),
        .out_valid(out_valid), .out_ready(out_ready), .wm_pix(wm_pix),
        .out_last(out_last)
`ifdef WM_STATS_EN
        , .stat_embed(stat_embed), .stat_resv(stat_resv)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int g_d1[1024], g_d2[1024], g_d3[1024], g_d4[1024], g_sym[1024], g_a1[1024], g_a2[1024];
    int exp_q[$];
    int g_last_pix;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Blend rules written directly as integer arithmetic.
    function automatic int model(input int i);
        int a, m, r;
        if (g_sym[i] == 1)      a = g_a1[i];
        else if (g_sym[i] == 2) a = g_a2[i];
        else                    return g_d1[i];
        if (a > 256) a = 256;
        m = (g_d2[i] + 2 * g_d3[i] + g_d4[i] + 2) / 4;
        r = (g_d1[i] * a + m * (256 - a) + 128) / 256;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic set_pix(input int i, input int p1, input int p2, input int p3, input int p4,
                           input int s, input int x1, input int x2);
        g_d1[i] = p1; g_d2[i] = p2; g_d3[i] = p3; g_d4[i] = p4;
        g_sym[i] = s; g_a1[i] = x1; g_a2[i] = x2;
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++)
            set_pix(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 511),
                    $urandom_range(0, 511));
    endtask

    // rmode: 0 = always ready, 1 = random valid/ready, 2 = 5-cycle stall at stall_at.
    task automatic run_frame(input int n, input int rmode, input int stall_at, input bit spurious,
                             input bit start_at_done, input int abort_after);
        int idx = 0, oc = 0, cyc = 0, last_hs = -10, e_emb = 0, e_res = 0;
        bit fin = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        frame_len = 20'(n); start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        while (!fin && cyc < 20000) begin
            start     = (spurious && cyc == 3) || (start_at_done && cyc == last_hs + 1);
            frame_len = (spurious && cyc == 3) ? 20'(n + 7) : 20'(n);
            in_valid  = (idx < n) && (rmode != 1 || $urandom_range(0, 3) != 0);
            if (idx < n) begin
                d1 = 8'(g_d1[idx]); d2 = 8'(g_d2[idx]); d3 = 8'(g_d3[idx]); d4 = 8'(g_d4[idx]);
                wm_sym = 2'(g_sym[idx]); a1 = 9'(g_a1[idx]); a2 = 9'(g_a2[idx]);
            end
            if (rmode == 1)      out_ready = ($urandom_range(0, 2) != 0);
            else if (rmode == 2) out_ready = !(cyc >= stall_at && cyc < stall_at + 5);
            else                 out_ready = 1'b1;
            #1;
            if (rmode == 2 && cyc == stall_at + 4) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(idx));
                if (g_sym[idx] == 1 || g_sym[idx] == 2) e_emb++;
                else if (g_sym[idx] == 3) e_res++;
                idx++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
                else check("wm_pix", wm_pix, exp_q.pop_front());
                check("out_last", out_last, (oc == n - 1) ? 1 : 0);
                g_last_pix = wm_pix;
                oc++;
                last_hs = cyc;
            end
            if (done) begin
                check("beats_at_done", oc, n);
                check("done_timing", cyc, last_hs + 1);
                fin = 1'b1;
            end
            if (abort_after > 0 && idx == abort_after) return;
            if (!fin) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("frame_complete", fin, 1);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("idle_after_done", busy, 0);
        check("no_out_after_done", out_valid, 0);
`ifdef WM_STATS_EN
        check("stat_embed", stat_embed, e_emb);
        check("stat_resv", stat_resv, e_res);
`else
        if (e_emb < 0 || e_res < 0) check("stat_model", 0, 1);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; frame_len = '0; in_valid = 1'b0; out_ready = 1'b1;
        d1 = '0; d2 = '0; d3 = '0; d4 = '0; wm_sym = '0; a1 = '0; a2 = '0;
        g_last_pix = 0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_wm_pix", wm_pix, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single embedded pixel; also a start pulse in the done cycle.
        set_pix(0, 200, 100, 100, 100, 1, 64, 0);
        run_frame(1, 0, 0, 1'b0, 1'b1, 0);
        check("t1_value", g_last_pix, 125);

        // Bypass symbols and a clamped alpha all return the host pixel.
        set_pix(0, 200, 100, 100, 100, 0, 64, 300);
        set_pix(1, 200, 100, 100, 100, 3, 64, 300);
        set_pix(2, 200, 100, 100, 100, 2, 64, 300);
        run_frame(3, 0, 0, 1'b0, 1'b0, 0);
        check("t2_value", g_last_pix, 200);

        // Mid-stream back-pressure plus an ignored start while busy.
        fill_rand(16);
        run_frame(16, 2, 6, 1'b1, 1'b0, 0);

        // Empty frame.
        @(posedge clk); #1;
        frame_len = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check("t4_busy", busy, 1);
        check("t4_done", done, 1);
        check("t4_in_ready", in_ready, 0);
        check("t4_out_valid", out_valid, 0);
        @(posedge clk); #2;
        check("t4_busy_end", busy, 0);
        check("t4_done_end", done, 0);

        // Reset after 4 of 8 pixels, then a complete frame.
        fill_rand(8);
        run_frame(8, 0, 0, 1'b0, 1'b0, 4);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_out_valid", out_valid, 0);
        check("t5_out_last", out_last, 0);
        check("t5_wm_pix", wm_pix, 0);
        check("t5_in_ready", in_ready, 0);
        rst = 1'b0;
        begin
            bit saw_done = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #2;
                if (done || out_valid) saw_done = 1'b1;
            end
            check("t5_quiet_after_rst", saw_done, 0);
        end
        fill_rand(8);
        run_frame(8, 0, 0, 1'b0, 1'b0, 0);

        // Long random frame with random handshakes.
        fill_rand(1000);
        run_frame(1000, 1, 0, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
